// File: rtl/display_scan_controller_pkg.sv
`include "display_defs.vh"
`default_nettype none
// ============================================================================
// Module   : display_scan_controller_pkg
// Brief    : Shared types and constants for the multiplexed display scanner.
// Revision : 1.0 - initial release
// ============================================================================
package display_scan_controller_pkg;

    localparam int c_default_prescale = `DISPLAY_DEFAULT_PRESCALE;
    localparam int c_nibble_w         = 4;

    typedef logic [c_nibble_w-1:0] nibble_t;

endpackage
`default_nettype wire

// File: rtl/display_defs.vh
// Shared display constants and helpers for the scan controller and its consumers.
`ifndef DISPLAY_DEFS_VH
`define DISPLAY_DEFS_VH

`define DISPLAY_ALL_OFF          7'b1111111
`define DISPLAY_DEFAULT_PRESCALE 50000
`define DISPLAY_NIBBLE(vec, i)   vec[4*(i) +: 4]

`endif

// File: rtl/display_scan_controller_scan_tick.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick
// Brief    : Slot prescaler; fim_slot marks the last cycle of every slot.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset,
    output logic fim_slot
);

    localparam int                 c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (fim_slot) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fim_slot = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`include "display_defs.vh"
`default_nettype none
// ============================================================================
// Module   : display_scan_controller
// Brief    : Time-multiplexed 7-segment digit scanner with frame-boundary
//            loading. Optional leading-zero blanking: DISPLAY_BLANK_ZEROS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = c_default_prescale
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   valor,
    output logic [c_nibble_w-1:0] digito,
    output logic [DIGITS-1:0]     ativo,
    output logic                  apagado,
    output logic                  atualizado
);

    localparam int                 c_idx_w    = $clog2(DIGITS);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

    logic                 w_fim_slot;
    logic                 w_fim_quadro;
    logic [c_idx_w-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_quadro;
    logic [4*DIGITS-1:0]  r_pendente;
    logic                 r_tem_pendente;
    logic [DIGITS-1:0]    w_onehot;

    scan_tick #(
        .PRESCALE (PRESCALE)
    ) u_scan_tick (
        .clock    (clock),
        .reset    (reset),
        .fim_slot (w_fim_slot)
    );

    assign w_fim_quadro = w_fim_slot && (r_idx == c_idx_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx          <= '0;
            r_quadro       <= '0;
            r_pendente     <= '0;
            r_tem_pendente <= 1'b0;
        end else begin
            if (w_fim_slot) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            // A load landing exactly on the boundary bypasses the pending register.
            if (w_fim_quadro) begin
                if (load) begin
                    r_quadro <= valor;
                end else if (r_tem_pendente) begin
                    r_quadro <= r_pendente;
                end
                r_tem_pendente <= 1'b0;
            end else if (load) begin
                r_pendente     <= valor;
                r_tem_pendente <= 1'b1;
            end
        end
    end

    assign w_onehot   = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
    assign ativo      = w_fim_slot ? '1 : ~w_onehot;
    assign digito     = `DISPLAY_NIBBLE(r_quadro, r_idx);
    assign atualizado = ~reset & w_fim_quadro & (load | r_tem_pendente);

`ifdef DISPLAY_BLANK_ZEROS_EN
    // w_zero_acima[i]: nibbles i..DIGITS-1 of the displayed frame are all zero.
    logic [DIGITS-1:0] w_zero_acima;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero_acima
        assign w_zero_acima[gi] = ~|r_quadro[4*DIGITS-1:4*gi];
    end

    assign apagado = (r_idx != '0) && w_zero_acima[r_idx];
`else
    assign apagado = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_controller
// Brief    : Scoreboard bench for display_scan_controller (DIGITS=4, PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_controller;

    localparam int D = 4;
    localparam int P = 4;
    localparam int W = 4 * D;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         load  = 1'b0;
    logic [W-1:0] valor = '0;
    logic [3:0]   digito;
    logic [D-1:0] ativo;
    logic         apagado;
    logic         atualizado;

    display_scan_controller #(
        .DIGITS   (D),
        .PRESCALE (P)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .valor      (valor),
        .digito     (digito),
        .ativo      (ativo),
        .apagado    (apagado),
        .atualizado (atualizado)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           em_reset;
        logic [3:0]   digito;
        logic [D-1:0] ativo;
        logic         apagado;
        logic         atualizado;
    } esperado_t;

    esperado_t fila[$];
    esperado_t e_mon;
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time since reset, displayed frame, pending frame.
    int           t = 0;
    logic [W-1:0] m_quadro = '0;
    logic [W-1:0] m_pend   = '0;
    bit           m_tem    = 1'b0;

    function automatic void chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endfunction

    task automatic passo(input bit rst, input bit ld, input logic [W-1:0] v);
        esperado_t e;
        int        slot;
        bit        dead;
        bit        bnd;
        reset = rst;
        load  = ld;
        valor = v;
        slot  = (t / P) % D;
        dead  = (t % P) == P - 1;
        bnd   = (t % (D * P)) == D * P - 1;
        e.em_reset   = rst;
        e.ativo      = dead ? '1 : ~(D'(1) << slot);
        e.digito     = 4'(m_quadro >> (4 * slot));
        e.atualizado = !rst && bnd && (ld || m_tem);
`ifdef DISPLAY_BLANK_ZEROS_EN
        e.apagado    = (slot > 0) && ((m_quadro >> (4 * slot)) == 0);
`else
        e.apagado    = 1'b0;
`endif
        fila.push_back(e);
        if (rst) begin
            t        = 0;
            m_quadro = '0;
            m_pend   = '0;
            m_tem    = 1'b0;
        end else begin
            if (bnd) begin
                if (ld)         m_quadro = v;
                else if (m_tem) m_quadro = m_pend;
                m_tem = 1'b0;
            end else if (ld) begin
                m_pend = v;
                m_tem  = 1'b1;
            end
            t++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic ate_fase(input int ph);
        while ((t % (D * P)) != ph) passo(1'b0, 1'b0, '0);
    endtask

    always @(negedge clock) begin
        if (fila.size() > 0) begin
            e_mon = fila.pop_front();
            chk("atualizado", {31'b0, atualizado}, {31'b0, e_mon.atualizado});
            if (!e_mon.em_reset) begin
                chk("ativo",   {28'b0, ativo},     {28'b0, e_mon.ativo});
                chk("digito",  {28'b0, digito},    {28'b0, e_mon.digito});
                chk("apagado", {31'b0, apagado},   {31'b0, e_mon.apagado});
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        int           k;
        @(posedge clock);
        #1;
        passo(1'b1, 1'b0, '0);
        passo(1'b1, 1'b1, 16'hFFFF);
        repeat (16) passo(1'b0, 1'b0, '0);

        ate_fase(2);  passo(1'b0, 1'b1, 16'h4321);
        ate_fase(0);  repeat (16) passo(1'b0, 1'b0, '0);

        ate_fase(3);  passo(1'b0, 1'b1, 16'h1111);
        ate_fase(9);  passo(1'b0, 1'b1, 16'h2222);
        ate_fase(0);  repeat (16) passo(1'b0, 1'b0, '0);

        ate_fase(15); passo(1'b0, 1'b1, 16'hABCD);
        repeat (4) passo(1'b0, 1'b0, '0);

        ate_fase(5);  passo(1'b0, 1'b1, 16'h00F0);
        repeat (3) passo(1'b0, 1'b0, '0);
        passo(1'b1, 1'b0, '0);
        repeat (20) passo(1'b0, 1'b0, '0);

        ate_fase(1);  passo(1'b0, 1'b1, 16'h0050);
        ate_fase(0);  repeat (16) passo(1'b0, 1'b0, '0);
        ate_fase(1);  passo(1'b0, 1'b1, 16'h0000);
        ate_fase(0);  repeat (16) passo(1'b0, 1'b0, '0);

        repeat (3000) begin
            for (int i = 0; i < D; i++) begin
                v[4*i +: 4] = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
            end
            passo(($urandom % 300) == 0, ($urandom % 8) == 0, v);
        end

        k = 0;
        while (fila.size() > 0 && k < 10) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (fila.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending entries expected 0", fila.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
